// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle datapath: FSM state codes, next-PC select
// encodings, ALU operation codes and the ALU evaluation function.
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [1:0] PCSRC_SEQ = 2'd0;
   localparam logic [1:0] PCSRC_BR  = 2'd1;
   localparam logic [1:0] PCSRC_J   = 2'd2;
   localparam logic [1:0] PCSRC_JR  = 2'd3;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;

   // Shifts move b by a[4:0], so a carries shamt when useshamt is set.
   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] y;
      y = '0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_NOR:  y = ~(a | b);
         ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: y = {31'b0, a < b};
         ALU_SLL:  y = b << a[4:0];
         ALU_SRL:  y = b >> a[4:0];
         ALU_SRA:  y = $signed(b) >>> a[4:0];
         ALU_LUI:  y = {b[15:0], 16'b0};
         default:  y = '0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/mc_fsm.sv
// Multi-cycle sequencer: state register, next-state and retire logic, and the
// registered data-memory request/write strobes.
module mc_fsm
   import mc_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   mem_rd_i,
   input  logic   mem_wr_i,
   input  logic   reg_wr_i,
   input  logic   link_i,
   input  logic   ack_i,
   output state_t state_o,
   output logic   retire_o,
   output logic   instr_done_o,
   output logic   req_o,
   output logic   we_o
);

   state_t state_q, state_d;
   logic   done_q, req_q, we_q;

   always_comb begin
      state_d  = S_FETCH;
      retire_o = 1'b0;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (mem_rd_i || mem_wr_i) begin
               state_d = S_MEM;
            end else if (reg_wr_i || link_i) begin
               state_d = S_WB;
            end else begin
               state_d  = S_FETCH;
               retire_o = 1'b1;
            end
         end
         S_MEM: begin
            // ack is only honoured here; a store retires directly.
            if (ack_i) begin
               if (we_q) begin
                  state_d  = S_FETCH;
                  retire_o = 1'b1;
               end else begin
                  state_d = S_WB;
               end
            end else begin
               state_d = S_MEM;
            end
         end
         S_WB: begin
            state_d  = S_FETCH;
            retire_o = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         done_q  <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= retire_o;
         req_q   <= (state_d == S_MEM);
         we_q    <= (state_d == S_MEM) && ((state_q == S_EXEC) ? mem_wr_i : we_q);
      end
   end

   assign state_o      = state_q;
   assign instr_done_o = done_q;
   assign req_o        = req_q;
   assign we_o         = we_q;

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-style datapath with external decode and a req/ack data port.
// Define MC_BYTE_MEM_EN to enable byte-lane stores and sign/zero-extended byte loads.
module mc_datapath
   import mc_pkg::*;
#(
   parameter int          IM_AW    = 10,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DM_AW    = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Branch,
   input  logic             Jump,
   input  logic             R,
   input  logic             RegDst,
   input  logic             J,
   input  logic             JumpReg,
   input  logic             link,
   input  logic             Byte,
   input  logic             ALUSrc,
   input  logic             RegWr,
   input  logic             MemWr,
   input  logic             MemRd,
   input  logic             Extop,
   input  logic             SigCtr,
   input  logic             useshamt,
   input  logic [1:0]       PCSrc,
   input  logic [3:0]       ALUctr,
   output logic [31:0]      Instruction,
   output logic             zero,
   output logic             negative,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [DM_AW-1:0] dmem_addr,
   output logic [31:0]      dmem_wdata,
   output logic [3:0]       dmem_be,
   input  logic [31:0]      dmem_rdata,
   input  logic             dmem_ack,
   output logic [2:0]       state,
   output logic             instr_done,
   input  logic             imem_we,
   input  logic [IM_AW-1:0] imem_waddr,
   input  logic [31:0]      imem_wdata
);

   state_t      state_q;
   logic        retire;
   logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, aluout_q, mdr_q, pcp4_q;
   logic        redir_q;
   logic [31:0] rf_q [32];
   logic [31:0] imem [0:(1 << IM_AW) - 1];

   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_ext, alu_a, alu_b, alu_y, target, wb_data, load_data;
   logic [4:0]  wb_addr;
   logic        take, wb_en, unused_ctl;

   mc_fsm u_fsm (
      .clk          (clk),
      .rst          (rst),
      .mem_rd_i     (MemRd),
      .mem_wr_i     (MemWr),
      .reg_wr_i     (RegWr),
      .link_i       (link),
      .ack_i        (dmem_ack),
      .state_o      (state_q),
      .retire_o     (retire),
      .instr_done_o (instr_done),
      .req_o        (dmem_req),
      .we_o         (dmem_we)
   );

   assign rs      = ir_q[25:21];
   assign rt      = ir_q[20:16];
   assign rd      = ir_q[15:11];
   assign imm_ext = Extop ? {{16{ir_q[15]}}, ir_q[15:0]} : {16'h0, ir_q[15:0]};
   assign alu_a   = useshamt ? {27'b0, ir_q[10:6]} : a_q;
   assign alu_b   = ALUSrc ? imm_q : b_q;
   assign alu_y   = alu_f(ALUctr, alu_a, alu_b);
   assign zero    = (alu_y == 32'h0);
   assign negative = alu_y[31];

   always_comb begin
      take   = 1'b0;
      target = pcp4_q;
      case (PCSrc)
         PCSRC_BR: begin
            take   = Branch && zero;
            target = pcp4_q + {imm_q[29:0], 2'b00};
         end
         PCSRC_J: begin
            take   = Jump || J;
            target = {pcp4_q[31:28], ir_q[25:0], 2'b00};
         end
         PCSRC_JR: begin
            take   = JumpReg;
            target = a_q;
         end
         default: ;
      endcase
   end

   assign wb_addr = link ? 5'd31 : (RegDst ? rd : rt);
   assign wb_data = link ? pcp4_q : (MemRd ? mdr_q : aluout_q);
   assign wb_en   = (state_q == S_WB) && (RegWr || link) && (wb_addr != 5'd0);

   assign dmem_addr = aluout_q[DM_AW-1:0];

`ifdef MC_BYTE_MEM_EN
   logic [1:0]  lane;
   logic [31:0] lane_word;
   assign lane       = aluout_q[1:0];
   assign lane_word  = dmem_rdata >> {lane, 3'b000};
   assign dmem_be    = Byte ? (4'b0001 << lane) : 4'b1111;
   assign dmem_wdata = Byte ? {4{b_q[7:0]}} : b_q;
   assign load_data  = !Byte  ? dmem_rdata :
                       SigCtr ? {{24{lane_word[7]}}, lane_word[7:0]} :
                                {24'h0, lane_word[7:0]};
   assign unused_ctl = ^{R, lane_word[31:8]};
`else
   assign dmem_be    = 4'b1111;
   assign dmem_wdata = b_q;
   assign load_data  = dmem_rdata;
   assign unused_ctl = ^{R, Byte, SigCtr};
`endif

   always_ff @(posedge clk) begin
      if (imem_we) imem[imem_waddr] <= imem_wdata;
   end

   // redir_q keeps a taken jump-and-link from being overwritten by pc+4 in WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         aluout_q <= '0;
         mdr_q    <= '0;
         pcp4_q   <= '0;
         redir_q  <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: ir_q <= imem[pc_q[IM_AW+1:2]];
            S_DECODE: begin
               a_q     <= rf_q[rs];
               b_q     <= rf_q[rt];
               imm_q   <= imm_ext;
               pcp4_q  <= pc_q + 32'd4;
               redir_q <= 1'b0;
            end
            S_EXEC: begin
               aluout_q <= alu_y;
               if (take) begin
                  pc_q    <= target;
                  redir_q <= 1'b1;
               end else if (retire) begin
                  pc_q <= pcp4_q;
               end
            end
            S_MEM: begin
               if (dmem_ack && !dmem_we) mdr_q <= load_data;
               if (retire && !redir_q) pc_q <= pcp4_q;
            end
            S_WB: if (!redir_q) pc_q <= pcp4_q;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (wb_en) begin
         rf_q[wb_addr] <= wb_data;
      end
   end

   assign Instruction = ir_q;
   assign state       = state_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed, table-driven bench for mc_datapath plus hand sequences for reset
// behaviour and an asynchronous reset during a pending memory access.
module tb_mc_datapath;
   import mc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Branch, Jump, R, RegDst, J, JumpReg, link, Byte, ALUSrc, RegWr;
   logic        MemWr, MemRd, Extop, SigCtr, useshamt;
   logic [1:0]  PCSrc;
   logic [3:0]  ALUctr;
   logic [31:0] Instruction;
   logic        zero, negative, dmem_req, dmem_we, dmem_ack, instr_done, imem_we;
   logic [11:0] dmem_addr;
   logic [31:0] dmem_wdata, dmem_rdata, imem_wdata;
   logic [3:0]  dmem_be;
   logic [2:0]  state;
   logic [9:0]  imem_waddr;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mc_datapath dut (
      .clk(clk), .rst(rst), .Branch(Branch), .Jump(Jump), .R(R), .RegDst(RegDst),
      .J(J), .JumpReg(JumpReg), .link(link), .Byte(Byte), .ALUSrc(ALUSrc),
      .RegWr(RegWr), .MemWr(MemWr), .MemRd(MemRd), .Extop(Extop), .SigCtr(SigCtr),
      .useshamt(useshamt), .PCSrc(PCSrc), .ALUctr(ALUctr), .Instruction(Instruction),
      .zero(zero), .negative(negative), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .state(state),
      .instr_done(instr_done), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata)
   );

   typedef enum int {K_NONE, K_ADDI, K_ORI, K_SUB, K_SLL, K_SW, K_LW, K_LB, K_BEQ} kind_t;

   typedef struct packed {
      logic Branch, Jump, R, RegDst, J, JumpReg, link, Byte, ALUSrc, RegWr;
      logic MemWr, MemRd, Extop, SigCtr, useshamt;
      logic [1:0] PCSrc;
      logic [3:0] ALUctr;
   } ctl_t;

   typedef struct {
      logic [31:0] instr;
      kind_t       k;
      int          dly;
      logic [31:0] rdata;
      int          rreg;
      logic [31:0] rval;
      int          cyc;
      logic [31:0] pc;
      int          req;
      int          we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } vec_t;

`ifdef MC_BYTE_MEM_EN
   localparam logic [31:0] LB_VAL = 32'hFFFF_FF80;
   localparam logic [3:0]  LB_BE  = 4'b1000;
`else
   localparam logic [31:0] LB_VAL = 32'h8012_3456;
   localparam logic [3:0]  LB_BE  = 4'b1111;
`endif

   function automatic ctl_t mk_ctl(input kind_t k);
      ctl_t c;
      c = '0;
      case (k)
         K_ADDI: begin c.ALUSrc = 1; c.RegWr = 1; c.Extop = 1; c.ALUctr = ALU_ADD; end
         K_ORI:  begin c.ALUSrc = 1; c.RegWr = 1; c.ALUctr = ALU_OR; end
         K_SUB:  begin c.R = 1; c.RegDst = 1; c.RegWr = 1; c.ALUctr = ALU_SUB; end
         K_SLL:  begin c.R = 1; c.RegDst = 1; c.RegWr = 1; c.useshamt = 1; c.ALUctr = ALU_SLL; end
         K_SW:   begin c.ALUSrc = 1; c.Extop = 1; c.MemWr = 1; c.ALUctr = ALU_ADD; end
         K_LW:   begin c.ALUSrc = 1; c.Extop = 1; c.MemRd = 1; c.RegWr = 1; c.ALUctr = ALU_ADD; end
         K_LB:   begin
            c.ALUSrc = 1; c.Extop = 1; c.MemRd = 1; c.RegWr = 1; c.ALUctr = ALU_ADD;
            c.Byte = 1; c.SigCtr = 1;
         end
         K_BEQ:  begin c.Branch = 1; c.Extop = 1; c.PCSrc = PCSRC_BR; c.ALUctr = ALU_SUB; end
         default: ;
      endcase
      return c;
   endfunction

   task automatic apply_ctl(input ctl_t c);
      Branch = c.Branch; Jump = c.Jump; R = c.R; RegDst = c.RegDst; J = c.J;
      JumpReg = c.JumpReg; link = c.link; Byte = c.Byte; ALUSrc = c.ALUSrc;
      RegWr = c.RegWr; MemWr = c.MemWr; MemRd = c.MemRd; Extop = c.Extop;
      SigCtr = c.SigCtr; useshamt = c.useshamt; PCSrc = c.PCSrc; ALUctr = c.ALUctr;
   endtask

   function automatic vec_t mkv(input logic [31:0] instr, input kind_t k, input int dly,
                                input logic [31:0] rdata, input int rreg,
                                input logic [31:0] rval, input int cyc, input logic [31:0] pc,
                                input int req, input int we, input logic [11:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
      vec_t v;
      v.instr = instr; v.k = k; v.dly = dly; v.rdata = rdata; v.rreg = rreg;
      v.rval = rval; v.cyc = cyc; v.pc = pc; v.req = req; v.we = we;
      v.addr = addr; v.wdata = wdata; v.be = be;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic write_imem(input int idx, input logic [31:0] data);
      imem_we = 1'b1; imem_waddr = idx[9:0]; imem_wdata = data;
      @(posedge clk); #1;
      imem_we = 1'b0;
   endtask

   // Runs one instruction from FETCH, acting as the memory responder.
   // Stray acks are driven in DECODE, where the design must ignore them.
   task automatic run_one(input int dly, input logic [31:0] rdata, output int cyc,
                          output int req_n, output int we_n, output logic [11:0] addr0,
                          output logic [31:0] wd0, output logic [3:0] be0,
                          output logic stable);
      int mem_n;
      cyc = 0; req_n = 0; we_n = 0; mem_n = 0; stable = 1'b1;
      addr0 = '0; wd0 = '0; be0 = '0;
      dmem_ack = 1'b0;
      while (1) begin
         @(posedge clk); #1;
         cyc++;
         dmem_ack = 1'b0;
         if (dmem_req) req_n++;
         if (dmem_we) we_n++;
         if (state == 3'd1) dmem_ack = 1'b1;
         if (state == 3'd3) begin
            if (mem_n == 0) begin
               addr0 = dmem_addr; wd0 = dmem_wdata; be0 = dmem_be;
            end else if (dmem_addr !== addr0 || dmem_wdata !== wd0) begin
               stable = 1'b0;
            end
            if (mem_n == dly) begin
               dmem_ack = 1'b1;
               dmem_rdata = rdata;
            end
            mem_n++;
         end
         if (instr_done || cyc >= 30) break;
      end
      dmem_ack = 1'b0;
   endtask

   vec_t vecs[12];

   initial begin
      int cyc, req_n, we_n, n;
      logic [11:0] addr0;
      logic [31:0] wd0;
      logic [3:0]  be0;
      logic        stable;

      vecs[0]  = mkv(32'h2001_0005, K_ADDI, 0, 0,            1, 32'd5,         4, 32'd4,  0, 0, 0, 0, 0);
      vecs[1]  = mkv(32'h3402_8000, K_ORI,  0, 0,            2, 32'h0000_8000, 4, 32'd8,  0, 0, 0, 0, 0);
      vecs[2]  = mkv(32'h2003_8000, K_ADDI, 0, 0,            3, 32'hFFFF_8000, 4, 32'd12, 0, 0, 0, 0, 0);
      vecs[3]  = mkv(32'h0022_2022, K_SUB,  0, 0,            4, 32'hFFFF_8005, 4, 32'd16, 0, 0, 0, 0, 0);
      vecs[4]  = mkv(32'h0001_2900, K_SLL,  0, 0,            5, 32'h0000_0050, 4, 32'd20, 0, 0, 0, 0, 0);
      vecs[5]  = mkv(32'h2000_0007, K_ADDI, 0, 0,            0, 32'd0,         4, 32'd24, 0, 0, 0, 0, 0);
      vecs[6]  = mkv(32'hAC01_0010, K_SW,   0, 0,            1, 32'd5,         4, 32'd28, 1, 1, 12'd16, 32'd5, 4'b1111);
      vecs[7]  = mkv(32'h8C06_0020, K_LW,   3, 32'hDEADBEEF, 6, 32'hDEADBEEF,  8, 32'd32, 4, 0, 12'd32, 0, 4'b1111);
      vecs[8]  = mkv(32'h8009_0003, K_LB,   1, 32'h8012_3456, 9, LB_VAL,       6, 32'd36, 2, 0, 12'd3, 0, LB_BE);
      vecs[9]  = mkv(32'h20E7_0001, K_ADDI, 0, 0,            7, 32'd1,         4, 32'd40, 0, 0, 0, 0, 0);
      vecs[10] = mkv(32'h1021_FFFE, K_BEQ,  0, 0,            7, 32'd1,         3, 32'd36, 0, 0, 0, 0, 0);
      vecs[11] = mkv(32'h20E7_0001, K_ADDI, 0, 0,            7, 32'd2,         4, 32'd40, 0, 0, 0, 0, 0);

      apply_ctl('0);
      dmem_ack = 1'b0; dmem_rdata = '0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;

      // Reset state; the program is loaded while reset is held.
      #2;
      check("rst.state", {29'b0, state}, 32'd0);
      check("rst.dmem_req", {31'b0, dmem_req}, 32'd0);
      check("rst.dmem_we", {31'b0, dmem_we}, 32'd0);
      check("rst.instr_done", {31'b0, instr_done}, 32'd0);
      check("rst.Instruction", Instruction, 32'd0);
      check("rst.pc", dut.pc_q, 32'd0);
      check("rst.zero", {31'b0, zero}, 32'd1);
      check("rst.negative", {31'b0, negative}, 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 11; i++) write_imem(i, vecs[i].instr);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         apply_ctl(mk_ctl(vecs[i].k));
         run_one(vecs[i].dly, vecs[i].rdata, cyc, req_n, we_n, addr0, wd0, be0, stable);
         $display("[TB] vec %0d instr=%h cycles=%0d pc=%h r%0d=%h", i, Instruction, cyc,
                  dut.pc_q, vecs[i].rreg, dut.rf_q[vecs[i].rreg]);
         check($sformatf("v%0d.cycles", i), cyc, vecs[i].cyc);
         check($sformatf("v%0d.instr", i), Instruction, vecs[i].instr);
         check($sformatf("v%0d.reg", i), dut.rf_q[vecs[i].rreg], vecs[i].rval);
         check($sformatf("v%0d.pc", i), dut.pc_q, vecs[i].pc);
         check($sformatf("v%0d.req_cycles", i), req_n, vecs[i].req);
         check($sformatf("v%0d.we_cycles", i), we_n, vecs[i].we);
         if (vecs[i].req > 0) begin
            check($sformatf("v%0d.addr", i), {20'b0, addr0}, {20'b0, vecs[i].addr});
            check($sformatf("v%0d.be", i), {28'b0, be0}, {28'b0, vecs[i].be});
            check($sformatf("v%0d.stable", i), {31'b0, stable}, 32'd1);
            if (vecs[i].we > 0)
               check($sformatf("v%0d.wdata", i), wd0, vecs[i].wdata);
         end
      end

      // Reset clears the register file; then reset again in the middle of a load.
      rst = 1'b1;
      @(posedge clk); #1;
      write_imem(0, 32'h8C08_0004);
      check("rst2.r1", dut.rf_q[1], 32'd0);
      check("rst2.pc", dut.pc_q, 32'd0);
      apply_ctl(mk_ctl(K_LW));
      dmem_ack = 1'b0;
      rst = 1'b0;
      n = 0;
      while (state != 3'd3 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      $display("[TB] lw reaching MEM after %0d cycles", n);
      check("midmem.enter", {29'b0, state}, 32'd3);
      @(posedge clk); #1;
      check("midmem.req_held", {31'b0, dmem_req}, 32'd1);
      #3;
      rst = 1'b1;
      #1;
      $display("[TB] async reset mid-MEM req=%0b state=%0d pc=%h", dmem_req, state, dut.pc_q);
      check("midmem.req_drop", {31'b0, dmem_req}, 32'd0);
      check("midmem.state", {29'b0, state}, 32'd0);
      check("midmem.pc", dut.pc_q, 32'd0);
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("midmem.r8", dut.rf_q[8], 32'd0);
      check("midmem.done", {31'b0, instr_done}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 SHALL have parameter IM_AW, default 10, meaning instruction-memory word-address width (depth 2**IM_AW words).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value after reset.
REQ-003 SHALL have parameter DM_AW, default 12, meaning data-memory byte-address width driven on dmem_addr.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-005 SHALL take Branch, Jump, R, RegDst, J, JumpReg, link, byte, ALUSrc, RegWr, MemWr, MemRd, Extop, SigCtr, useshamt  in  1 each  decoded control, sampled only in the states that use them.
REQ-006 SHALL take PCSrc  in  2  next-PC select, and ALUctr  in  4  ALU operation.
REQ-007 SHALL drive Instruction  out  32  IR contents; zero  out  1; negative  out  1  ALU flags.
REQ-008 SHALL drive dmem_req  out  1; dmem_we  out  1; dmem_addr  out  DM_AW; dmem_wdata  out  32; dmem_be  out  4; and take dmem_rdata  in  32; dmem_ack  in  1.
REQ-009 SHALL drive state  out  3  current FSM state, and instr_done  out  1  one-cycle retire pulse.

Function
REQ-010 SHALL sequence states FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4); codes 5-7 SHALL go to FETCH.
REQ-011 FETCH: IR <= imem[pc[IM_AW+1:2]]; next DECODE.
REQ-012 DECODE: register A <= RegFile[rs], B <= RegFile[rt], imm32 latched per Extop; next EXEC.
REQ-013 EXEC: ALUOut <= ALU(useshamt ? shamt : A, ALUSrc ? imm32 : B); next MEM if MemRd|MemWr, else WB if RegWr|link, else FETCH with PC update and instr_done.
REQ-014 Branch/jump instructions SHALL update PC at end of EXEC via PCSrc; non-taken and non-branch instructions SHALL update PC to pc+4 at retirement.
REQ-015 MEM: dmem_req=1, dmem_we=MemWr, dmem_addr=ALUOut[DM_AW-1:0], dmem_wdata=B, held stable until dmem_ack; ack in first MEM cycle SHALL be accepted (zero wait states).
REQ-016 On ack: load SHALL latch MDR <= dmem_rdata and go WB; store SHALL retire and go FETCH.
REQ-017 dmem_ack outside MEM SHALL be ignored; dmem_req SHALL deassert in the cycle after ack.
REQ-018 WB: RegFile write enabled only in WB; data = link ? pc+4 : (MemRd ? MDR : ALUOut); address = link ? 31 : (RegDst ? rd : rt); retire, go FETCH.
REQ-019 Writes to register 0 SHALL be discarded; instr_done SHALL pulse exactly once per instruction (3-5 cycles + memory wait).
REQ-020 PC wrap beyond 2**IM_AW words SHALL alias modulo depth, no error.

Reset
REQ-021 rst SHALL force state=FETCH, pc=RESET_PC, IR/A/B/ALUOut/MDR=0, dmem_req=0, dmem_we=0, instr_done=0, regfile cleared.
REQ-022 rst during MEM SHALL drop dmem_req asynchronously; the pending access SHALL be abandoned with no register write.

Configuration
REQ-023 Macro MC_BYTE_MEM_EN defined: byte=1 SHALL set dmem_be to one-hot of ALUOut[1:0], replicate B[7:0] on all lanes, and extract the addressed load byte sign/zero-extended per SigCtr.
REQ-024 Macro undefined: byte and SigCtr SHALL be ignored, dmem_be SHALL be 4'b1111, all accesses word-wide.

Structure
REQ-025 Package mc_pkg SHALL hold the state enum, state codes, and PCSrc encodings.
REQ-026 Sub-module mc_fsm SHALL contain state register and next-state/retire logic; existing ALU, RegFile, Extend, NPC, InstructionCut SHALL be reused.

Verification
REQ-027 addi $1,$0,5 from reset -> 4 cycles FETCH-DECODE-EXEC-WB, $1=5, pc=4, one instr_done.
REQ-028 lw with dmem_ack delayed 3 cycles, rdata=32'hDEADBEEF -> req held 4 cycles, addr stable, rt=DEADBEEF.
REQ-029 sw zero-wait (ack same cycle) -> dmem_we=1 one cycle, no RegFile write, retire after 4 cycles.
REQ-030 beq taken, offset -2 -> pc=pc+4-8 at end of EXEC, 3-cycle instruction.
REQ-031 rst asserted mid-MEM -> dmem_req=0 immediately, pc=RESET_PC, state=FETCH.
REQ-032 With MC_BYTE_MEM_EN, lb at addr 3, rdata=32'h80xxxxxx, SigCtr=1 -> rt=32'hFFFFFF80, dmem_be=4'b1000.
